// File: rtl/round_sequencer_if.sv
// Handshake bundle between the debounced pushbuttons/scorer and the round_sequencer.
// The master side drives buttons and game_over; the slave side (the sequencer) drives the round outputs.
`timescale 1ns/1ps
interface round_sequencer_if;
    logic pb_l;
    logic pb_r;
    logic game_over;
    logic leds_on;
    logic fake;
    logic winrnd;
    logic right;
    logic tie;
    logic busy;

    modport master (
        output pb_l, pb_r, game_over,
        input  leds_on, fake, winrnd, right, tie, busy
    );

    modport slave (
        input  pb_l, pb_r, game_over,
        output leds_on, fake, winrnd, right, tie, busy
    );
endinterface

// File: rtl/round_sequencer.sv
// Tug-of-war round controller: random lights-off delay, lit window, first-push detection.
// Optional fake rounds are enabled by defining FAKE_ROUND_EN.
`timescale 1ns/1ps
module round_sequencer #(
    parameter int DELAY_MIN   = 16,
    parameter int DELAY_W     = 8,
    parameter int LIT_TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    round_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT,
        LIT,
        RESULT,
        HOLD,
        HALT
    } state_t;

    // Counter runs down to zero, so loads are one less than the wanted cycle count.
    localparam logic [15:0] DELAY_BASE = 16'(DELAY_MIN - 1);
    localparam logic [15:0] LIT_LOAD   = 16'(LIT_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pb_l_q, pb_r_q;
    logic        leds_on_q, leds_on_d;
    logic        winrnd_q, winrnd_d;
    logic        right_q, right_d;
    logic        tie_q, tie_d;
    logic        busy_q, busy_d;

    logic edge_l, edge_r, push, released;

    assign edge_l   = bus.pb_l & ~pb_l_q;
    assign edge_r   = bus.pb_r & ~pb_r_q;
    assign push     = edge_l | edge_r;
    assign released = ~bus.pb_l & ~bus.pb_r;
    assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        right_d   = 1'b0;
        tie_d     = 1'b0;
        leds_on_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.game_over) begin
                    state_d = HALT;
                end else if (released) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                cnt_d   = DELAY_BASE + 16'(lfsr_q[DELAY_W-1:0]);
                state_d = WAIT;
            end
            WAIT: begin
                // A push wins over expiry: pressing on the last dark cycle is still a jump.
                if (push) begin
                    right_d = edge_r & ~edge_l;
                    tie_d   = edge_l & edge_r;
                    state_d = RESULT;
                end else if (cnt_q == 16'd0) begin
                    cnt_d   = LIT_LOAD;
                    state_d = LIT;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            LIT: begin
                if (push) begin
                    right_d   = edge_r & ~edge_l;
                    tie_d     = edge_l & edge_r;
                    leds_on_d = 1'b1;
                    state_d   = RESULT;
                end else if (cnt_q == 16'd0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RESULT: state_d = HOLD;
            HOLD: begin
                if (released) begin
                    state_d = IDLE;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        if (state_d == LIT) begin
            leds_on_d = 1'b1;
        end
        winrnd_d = (state_d == RESULT);
        busy_d   = (state_d != IDLE) && (state_d != HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= 16'hACE1;
            cnt_q     <= 16'd0;
            pb_l_q    <= 1'b0;
            pb_r_q    <= 1'b0;
            leds_on_q <= 1'b0;
            winrnd_q  <= 1'b0;
            right_q   <= 1'b0;
            tie_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            pb_l_q    <= bus.pb_l;
            pb_r_q    <= bus.pb_r;
            leds_on_q <= leds_on_d;
            winrnd_q  <= winrnd_d;
            right_q   <= right_d;
            tie_q     <= tie_d;
            busy_q    <= busy_d;
        end
    end

`ifdef FAKE_ROUND_EN
    logic fake_q, fake_d;

    // Decided once in ARM and held until the round result has been reported.
    always_comb begin
        fake_d = fake_q;
        if (state_q == ARM) begin
            fake_d = lfsr_q[15] & lfsr_q[14];
        end
        if ((state_d == HOLD) || (state_d == IDLE) || (state_d == HALT)) begin
            fake_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fake_q <= 1'b0;
        end else begin
            fake_q <= fake_d;
        end
    end

    assign bus.fake = fake_q;
`else
    assign bus.fake = 1'b0;
`endif

    assign bus.leds_on = leds_on_q;
    assign bus.winrnd  = winrnd_q;
    assign bus.right   = right_q;
    assign bus.tie     = tie_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with a scoreboard of expected round results
// and a reference LFSR used to predict the lights-off delay and fake decision.
`timescale 1ns/1ps
module tb_round_sequencer;
    localparam int DMIN = 4;
    localparam int DW   = 2;
    localparam int LT   = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    // {right, tie, lit, fake}
    logic [3:0]  exp_q[$];
    logic [15:0] ref_lfsr;

    round_sequencer_if bus ();

    round_sequencer #(
        .DELAY_MIN  (DMIN),
        .DELAY_W    (DW),
        .LIT_TIMEOUT(LT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) ref_lfsr <= 16'hACE1;
        else     ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every winrnd pulse must match the oldest expected result.
    always @(negedge clk) begin
        logic [3:0] e;
        if (rst === 1'b0 && bus.winrnd !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk1("winrnd_unexpected", bus.winrnd, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk1("winrnd", bus.winrnd, 1'b1);
                chk1("right", bus.right, e[3]);
                chk1("tie", bus.tie, e[2]);
                chk1("leds_on_lit", bus.leds_on, e[1]);
                chk1("fake_result", bus.fake, e[0]);
                $display("round result: right=%b tie=%b lit=%b fake=%b", bus.right, bus.tie, bus.leds_on, bus.fake);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the ARM cycle and predicts this round's delay and fake flag.
    task automatic start_round(output int d, output logic f);
        logic got;
        got = 1'b0;
        chk1("idle_before_round", bus.busy, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.busy === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk1("arm_timeout", bus.busy, 1'b1);
        d = DMIN + int'(ref_lfsr[DW-1:0]);
`ifdef FAKE_ROUND_EN
        f = ref_lfsr[15] & ref_lfsr[14];
`else
        f = 1'b0;
`endif
    endtask

    // Counts dark WAIT cycles after ARM; returns with leds_on just risen.
    task automatic wait_lit(input int d);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.leds_on === 1'b1) begin
                got = 1'b1;
                break;
            end
            n++;
        end
        if (!got) chk1("lit_timeout", bus.leds_on, 1'b1);
        chkn("wait_len", n, d);
    endtask

    initial begin
        int   d;
        int   n;
        logic f;
        logic seen;

        bus.pb_l      = 1'b0;
        bus.pb_r      = 1'b0;
        bus.game_over = 1'b0;
        repeat (3) tick();
        chk1("rst_leds_on", bus.leds_on, 1'b0);
        chk1("rst_fake", bus.fake, 1'b0);
        chk1("rst_winrnd", bus.winrnd, 1'b0);
        chk1("rst_right", bus.right, 1'b0);
        chk1("rst_tie", bus.tie, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;

        // Right push two cycles after the lights come on.
        start_round(d, f);
        wait_lit(d);
        tick();
        tick();
        bus.pb_r = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 1'b1, f});
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("busy_hold", bus.busy, 1'b1);
            chk1("leds_hold", bus.leds_on, 1'b0);
        end
        chkn("sb_drained_right", exp_q.size(), 0);
        bus.pb_r = 1'b0;
        tick();
        chk1("busy_after_release", bus.busy, 1'b0);

        // Jump the light during WAIT.
        start_round(d, f);
        tick();
        bus.pb_l = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 1'b0, f});
        tick();
        chk1("jump_leds_off", bus.leds_on, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen = seen | bus.leds_on;
        end
        chk1("jump_never_lit", seen, 1'b0);
        chkn("sb_drained_jump", exp_q.size(), 0);
        bus.pb_l = 1'b0;
        tick();

        // Both buttons on the same edge while lit.
        start_round(d, f);
        wait_lit(d);
        bus.pb_l = 1'b1;
        bus.pb_r = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 1'b1, f});
        tick();
        tick();
        chkn("sb_drained_tie", exp_q.size(), 0);
        bus.pb_l = 1'b0;
        bus.pb_r = 1'b0;
        tick();

        // No push: lit window is exactly LT cycles, then back to IDLE.
        start_round(d, f);
        wait_lit(d);
        n = 1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.leds_on !== 1'b1) break;
            n++;
        end
        chkn("lit_len", n, LT);
        tick();
        chk1("timeout_idle", bus.busy, 1'b0);

        // Button pressed in ARM and held through the round never scores.
        start_round(d, f);
        bus.pb_l = 1'b1;
        wait_lit(d);
        repeat (LT + 3) tick();
        chk1("held_in_hold", bus.busy, 1'b1);
        bus.pb_l = 1'b0;
        tick();
        chk1("held_released_idle", bus.busy, 1'b0);

        // A fresh press after release scores normally.
        start_round(d, f);
        wait_lit(d);
        bus.pb_r = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 1'b1, f});
        tick();
        tick();
        chkn("sb_drained_repush", exp_q.size(), 0);
        bus.pb_r = 1'b0;
        tick();

        // Reset mid-round aborts without a result.
        start_round(d, f);
        wait_lit(d);
        rst      = 1'b1;
        bus.pb_r = 1'b1;
        tick();
        chk1("abort_winrnd", bus.winrnd, 1'b0);
        chk1("abort_busy", bus.busy, 1'b0);
        chk1("abort_leds", bus.leds_on, 1'b0);
        rst      = 1'b0;
        bus.pb_r = 1'b0;

        // Many short rounds: fake flag against the reference LFSR.
        for (int r = 0; r < 200; r++) begin
            start_round(d, f);
            tick();
            chk1("fake_wait", bus.fake, f);
            bus.pb_l = 1'b1;
            exp_q.push_back({1'b0, 1'b0, 1'b0, f});
            tick();
            tick();
            chk1("fake_hold_clear", bus.fake, 1'b0);
            bus.pb_l = 1'b0;
            tick();
        end
        chkn("sb_drained_fake", exp_q.size(), 0);

        // game_over mid-round lets the round finish, then HALT blocks everything.
        start_round(d, f);
        tick();
        bus.game_over = 1'b1;
        wait_lit(d - 1);
        bus.pb_l = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 1'b1, f});
        tick();
        tick();
        chkn("sb_drained_gameover", exp_q.size(), 0);
        bus.pb_l = 1'b0;
        tick();
        tick();
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.pb_l = i[0];
            bus.pb_r = i[1];
            tick();
            seen = seen | bus.busy | bus.leds_on | bus.winrnd;
        end
        chk1("halt_quiet", seen, 1'b0);
        bus.pb_l      = 1'b0;
        bus.pb_r      = 1'b0;
        bus.game_over = 1'b0;
        repeat (5) tick();
        chk1("halt_sticky", bus.busy, 1'b0);
        rst = 1'b1;
        tick();
        chk1("rst_from_halt_busy", bus.busy, 1'b0);
        rst = 1'b0;
        tick();
        chk1("rearm_after_rst", bus.busy, 1'b1);
        chkn("sb_final_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
